// File: rtl/noc_pkg.sv
// Packet layout and type encodings shared by the NoC ingress arbiter files.
// The fixed 13-bit layout is {hdr, payload[7:0], type[1:0], addr[1:0]}.
package noc_pkg;
  localparam int PKT_W       = 13;
  localparam int HDR_BIT     = 12;
  localparam int PAYLOAD_MSB = 11;
  localparam int PAYLOAD_LSB = 4;
  localparam int TYPE_MSB    = 3;
  localparam int TYPE_LSB    = 2;
  localparam int ADDR_MSB    = 1;
  localparam int ADDR_LSB    = 0;

  typedef enum logic [1:0] {
    PKT_DATA = 2'b00,
    PKT_CTRL = 2'b01,
    PKT_RESP = 2'b10,
    PKT_RSVD = 2'b11
  } pkt_type_e;

  typedef struct packed {
    logic       hdr;
    logic [7:0] payload;
    pkt_type_e  ptype;
    logic [1:0] addr;
  } packet_t;
endpackage

// File: rtl/noc_ingress_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int   w_pos;
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int off = 1; off <= N; off++) begin
      w_pos = (int'(i_ptr) + off) % N;
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IW'(w_pos);
      end
    end
    o_any = |i_req;
  end
endmodule

// File: rtl/noc_ingress_arbiter.sv
// Round-robin share of the NoC ingress port with a registered output slot,
// hdr=0 drop counting and a sticky stall watchdog. NOC_ARB_CTRL_PRIO_EN: control packets first.
module noc_ingress_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PKT_W     = noc_pkg::PKT_W,
  parameter int STALL_LIM = 64,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ*PKT_W-1:0] req_packet,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [PKT_W-1:0]         packet,
  output logic                     pack_valid,
  input  logic                     nocr_ready,
  output logic [IW-1:0]            grant_id,
  output logic [7:0]               drop_cnt,
  output logic                     stall_err
);
  localparam int SW = $clog2(STALL_LIM + 1);

  logic [IW-1:0]      r_ptr;
  logic [PKT_W-1:0]   r_packet;
  logic               r_pack_valid;
  logic [IW-1:0]      r_grant_id;
  logic [7:0]         r_drop_cnt;
  logic [SW-1:0]      r_stall_cnt;
  logic               r_stall_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic               w_slot_free;
  logic               w_xfer;
  logic [PKT_W-1:0]   w_win_pkt;
  packet_t            w_win;

`ifdef NOC_ARB_CTRL_PRIO_EN
  logic [NUM_REQ-1:0] w_ctrl_req;
  logic [NUM_REQ-1:0] w_ctrl_grant, w_norm_grant;
  logic [IW-1:0]      w_ctrl_idx, w_norm_idx;
  logic               w_ctrl_any, w_norm_any;

  always_comb begin
    w_ctrl_req = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_ctrl_req[i] = req_valid[i] &&
        (req_packet[i*PKT_W+TYPE_LSB +: 2] == PKT_CTRL);
  end

  rr_arbiter #(.N(NUM_REQ)) u_ctrl_arb (
    .i_req(w_ctrl_req), .i_ptr(r_ptr),
    .o_grant(w_ctrl_grant), .o_idx(w_ctrl_idx), .o_any(w_ctrl_any)
  );
  rr_arbiter #(.N(NUM_REQ)) u_norm_arb (
    .i_req(req_valid), .i_ptr(r_ptr),
    .o_grant(w_norm_grant), .o_idx(w_norm_idx), .o_any(w_norm_any)
  );

  assign w_grant = w_ctrl_any ? w_ctrl_grant : w_norm_grant;
  assign w_idx   = w_ctrl_any ? w_ctrl_idx   : w_norm_idx;
  assign w_any   = w_norm_any;
`else
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req(req_valid), .i_ptr(r_ptr),
    .o_grant(w_grant), .o_idx(w_idx), .o_any(w_any)
  );
`endif

  // Handshake: a requester transfers on a rising edge when req_valid[i] & req_ready[i];
  // the NoC takes the output when pack_valid & nocr_ready. A grant is offered only
  // when the output slot is empty or being emptied in the same cycle.
  assign w_slot_free = !r_pack_valid || nocr_ready;
  assign req_ready   = (reset && w_slot_free && w_any) ? w_grant : '0;
  assign w_xfer      = |(req_valid & req_ready);
  assign w_win_pkt   = req_packet[w_idx*PKT_W +: PKT_W];
  assign w_win       = packet_t'(w_win_pkt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr        <= IW'(NUM_REQ - 1);
      r_packet     <= '0;
      r_pack_valid <= 1'b0;
      r_grant_id   <= '0;
      r_drop_cnt   <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_idx;
      if (w_win.hdr) begin
        r_packet     <= w_win_pkt;
        r_grant_id   <= w_idx;
        r_pack_valid <= 1'b1;
      end else begin
        r_pack_valid <= 1'b0;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (nocr_ready) begin
      r_pack_valid <= 1'b0;
    end
  end

  // Counter saturates at the limit; the error flag stays set until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else if (r_pack_valid && !nocr_ready) begin
      if (r_stall_cnt != SW'(STALL_LIM)) r_stall_cnt <= r_stall_cnt + SW'(1);
      if (r_stall_cnt == SW'(STALL_LIM - 1)) r_stall_err <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign packet     = r_packet;
  assign pack_valid = r_pack_valid;
  assign grant_id   = r_grant_id;
  assign drop_cnt   = r_drop_cnt;
  assign stall_err  = r_stall_err;
endmodule

// File: tb/tb_noc_ingress_arbiter.sv
// Bench for noc_ingress_arbiter: vector table for arbitration order plus sequences
// for stall watchdog, drop saturation, control priority and mid-traffic reset.
module tb_noc_ingress_arbiter;
  localparam int N = 4;
  localparam int W = 13;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N*W-1:0] req_packet = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   packet;
  logic           pack_valid;
  logic           nocr_ready = 1'b0;
  logic [1:0]     grant_id;
  logic [7:0]     drop_cnt;
  logic           stall_err;

  always #5 clk = ~clk;

  noc_ingress_arbiter #(.NUM_REQ(N), .PKT_W(W), .STALL_LIM(8)) dut (
    .clk(clk), .reset(reset), .req_packet(req_packet), .req_valid(req_valid),
    .req_ready(req_ready), .packet(packet), .pack_valid(pack_valid),
    .nocr_ready(nocr_ready), .grant_id(grant_id), .drop_cnt(drop_cnt),
    .stall_err(stall_err)
  );

  typedef struct {
    string          name;
    logic [N-1:0]   valid;
    logic [N*W-1:0] pkts;
    logic           nrdy;
    logic [N-1:0]   exp_rr;
  } vec_t;

  vec_t           vecs[7];
  logic [14:0]    exp_q[$];
  int             n_checks = 0;
  int             n_pass = 0;
  logic           exp_pv;
  logic [W-1:0]   exp_pkt;
  logic [1:0]     exp_gid;
  logic [7:0]     exp_drop;

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] p0, input logic [W-1:0] p1,
                                        input logic [W-1:0] p2, input logic [W-1:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle, check the combinational grant, then check the registered result.
  task automatic apply(input string name, input logic [N-1:0] v, input logic [N*W-1:0] p,
                       input logic nr, input logic [N-1:0] exp_rr);
    int          idx;
    logic [W-1:0] pk;
    logic        pushed;
    logic [14:0] item;
    req_valid  = v;
    req_packet = p;
    nocr_ready = nr;
    #1;
    chk({name, "_req_ready"}, 32'(req_ready), 32'(exp_rr));
    pushed = 1'b0;
    idx    = 0;
    if (exp_rr != '0) begin
      for (int i = 0; i < N; i++) if (exp_rr[i]) idx = i;
      pk = p[idx*W +: W];
      if (pk[12]) begin
        exp_q.push_back({2'(idx), pk});
        exp_pv  = 1'b1;
        exp_pkt = pk;
        exp_gid = 2'(idx);
        pushed  = 1'b1;
      end else begin
        exp_pv = 1'b0;
        if (exp_drop != 8'hFF) exp_drop++;
      end
    end else if (nr) begin
      exp_pv = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({name, "_pack_valid"}, 32'(pack_valid), 32'(exp_pv));
    if (pushed) begin
      item = exp_q.pop_front();
      chk({name, "_packet"}, 32'(packet), 32'(item[12:0]));
      chk({name, "_grant_id"}, 32'(grant_id), 32'(item[14:13]));
    end else if (exp_pv) begin
      chk({name, "_packet_held"}, 32'(packet), 32'(exp_pkt));
      chk({name, "_grant_id_held"}, 32'(grant_id), 32'(exp_gid));
    end
    chk({name, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_pack_valid"}, 32'(pack_valid), 0);
    chk({name, "_packet"}, 32'(packet), 0);
    chk({name, "_grant_id"}, 32'(grant_id), 0);
    chk({name, "_drop_cnt"}, 32'(drop_cnt), 0);
    chk({name, "_stall_err"}, 32'(stall_err), 0);
    chk({name, "_req_ready"}, 32'(req_ready), 0);
  endtask

  initial begin
    logic [N*W-1:0] all_pk;
    logic [N-1:0]   prio_exp;
    logic [W-1:0]   dpk;
    int             r;

    all_pk   = mk(13'h1001, 13'h1102, 13'h1203, 13'h1304);
    vecs[0]  = '{"rr0", 4'b1111, all_pk, 1'b1, 4'b0001};
    vecs[1]  = '{"rr1", 4'b1111, all_pk, 1'b1, 4'b0010};
    vecs[2]  = '{"rr2", 4'b1111, all_pk, 1'b1, 4'b0100};
    vecs[3]  = '{"rr3", 4'b1111, all_pk, 1'b1, 4'b1000};
    vecs[4]  = '{"rr4", 4'b1111, all_pk, 1'b1, 4'b0001};
    vecs[5]  = '{"req0_only", 4'b0001, mk(13'h1A5C, 13'h0, 13'h0, 13'h0), 1'b1, 4'b0001};
    vecs[6]  = '{"idle", 4'b0000, '0, 1'b1, 4'b0000};

    // Reset held with requests pending
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_packet = all_pk;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    exp_pv   = 1'b0;
    exp_pkt  = '0;
    exp_gid  = '0;
    exp_drop = '0;
    reset    = 1'b1;

    foreach (vecs[k]) apply(vecs[k].name, vecs[k].valid, vecs[k].pkts, vecs[k].nrdy, vecs[k].exp_rr);

    // Stall: slot held for 10 cycles, watchdog trips on the 8th
    apply("stall_load", 4'b0100, mk(13'h0, 13'h0, 13'h1333, 13'h0), 1'b1, 4'b0100);
    for (int i = 1; i <= 10; i++) begin
      apply("stall", 4'b1111, all_pk, 1'b0, 4'b0000);
      chk($sformatf("stall_err_c%0d", i), 32'(stall_err), 32'(i >= 8));
    end
    apply("stall_release", 4'b0000, '0, 1'b1, 4'b0000);
    chk("stall_err_sticky", 32'(stall_err), 1);

    // Drops of hdr=0 packets and saturation of the drop counter
    apply("drop_first", 4'b0100, mk(13'h0, 13'h0, 13'h0FF0, 13'h0), 1'b1, 4'b0100);
    chk("drop_cnt_one", 32'(drop_cnt), 1);
    for (int k = 0; k < 260; k++) begin
      r   = $urandom_range(0, N - 1);
      dpk = {1'b0, 12'($urandom)};
      apply("drop_sat", 4'(1 << r), (N*W)'(dpk) << (r * W), 1'b1, 4'(1 << r));
    end
    chk("drop_cnt_sat", 32'(drop_cnt), 255);

    // Control-type priority: req1 data vs req3 control, ptr at 0
    apply("prio_set", 4'b0001, mk(13'h1111, 13'h0, 13'h0, 13'h0), 1'b1, 4'b0001);
`ifdef NOC_ARB_CTRL_PRIO_EN
    prio_exp = 4'b1000;
`else
    prio_exp = 4'b0010;
`endif
    apply("prio", 4'b1010, mk(13'h0, 13'h1210, 13'h0, 13'h1224), 1'b1, prio_exp);
    apply("prio_drain", 4'b0000, '0, 1'b1, 4'b0000);

    // Reset with a packet held in the output slot
    apply("mid_load", 4'b0001, mk(13'h1777, 13'h0, 13'h0, 13'h0), 1'b1, 4'b0001);
    apply("mid_hold", 4'b0000, '0, 1'b0, 4'b0000);
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_packet = all_pk;
    nocr_ready = 1'b1;
    #1;
    chk_reset_state("mid_reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("mid_reset_edge");
    reset = 1'b1;
    exp_q.delete();
    exp_pv   = 1'b0;
    exp_pkt  = '0;
    exp_gid  = '0;
    exp_drop = '0;
    apply("post_reset", 4'b1111, all_pk, 1'b1, 4'b0001);
    apply("post_drain", 4'b0000, '0, 1'b1, 4'b0000);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
